// File: rtl/lut_u_arbiter_if.sv
// Bundle of the two LUT-U request channels, the shared LUT-U port and the
// tagged result channel. The arbiter connects through the slave modport;
// requesters, the LUT-U instance and the result consumer sit on the master side.
interface lut_u_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [ADDR_WIDTH-1:0] lut_addr;
  logic [DATA_WIDTH-1:0] lut_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_id;
  logic                  out_err;
  logic                  err_sticky;

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr, lut_q, out_ready,
    output req0_ready, req1_ready, lut_addr, out_valid, out_data, out_id,
           out_err, err_sticky
  );

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr, lut_q, out_ready,
    input  req0_ready, req1_ready, lut_addr, out_valid, out_data, out_id,
           out_err, err_sticky
  );
endinterface

// File: rtl/lut_u_arbiter.sv
// Two-port round-robin arbiter and two-stage sequencer for the shared LUT-U.
// Stage A registers the granted address (driving the LUT directly), stage B
// captures the LUT value together with the requester id.
// Optional feature macro: LUT_U_ARB_CHECK_EN -- when defined, flags accepted
// addresses whose symbol exceeds nsyms_m1 (out_err / err_sticky); otherwise
// both outputs are tied low.
module lut_u_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  lut_u_arbiter_if.slave       bus
);

  localparam int HALF = ADDR_WIDTH / 2;

  logic                  a_valid;
  logic                  a_id;
  logic [ADDR_WIDTH-1:0] lut_addr;
  logic                  last_grant;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_id;
  logic                  out_err;
  logic                  err_sticky;

  logic b_free;
  logic a_adv;
  logic a_free;
  logic sel0;
  logic sel1;
  logic accept;
  logic [ADDR_WIDTH-1:0] acc_addr;

  // Handshake and round-robin selection; ready only ever follows a valid.
  always_comb begin
    b_free   = !out_valid || bus.out_ready;
    a_adv    = a_valid && b_free;
    a_free   = !a_valid || b_free;
    sel0     = bus.req0_valid && (!bus.req1_valid || last_grant);
    sel1     = bus.req1_valid && (!bus.req0_valid || !last_grant);
    accept   = (sel0 || sel1) && a_free;
    acc_addr = sel1 ? bus.req1_addr : bus.req0_addr;
  end

  // Stage A: capture the granted address; lut_addr holds when idle so the
  // shared LUT input does not toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid    <= 1'b0;
      a_id       <= 1'b0;
      lut_addr   <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      a_valid    <= 1'b1;
      a_id       <= sel1;
      lut_addr   <= acc_addr;
      last_grant <= sel1;
    end else if (a_adv) begin
      a_valid    <= 1'b0;
    end
  end

  // Stage B: load from A whenever B is free, otherwise drain or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
    end else if (a_adv) begin
      out_valid <= 1'b1;
      out_data  <= bus.lut_q;
      out_id    <= a_id;
    end else if (b_free) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LUT_U_ARB_CHECK_EN
  logic a_err;

  // Range flag travels with the address through A into B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_err   <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (accept) a_err <= (acc_addr[HALF-1:0] > acc_addr[ADDR_WIDTH-1:HALF]);
      if (a_adv) out_err <= a_err;
    end
  end

  // Sticky error records any flagged result the consumer actually took.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_sticky <= 1'b0;
    else if (out_valid && bus.out_ready && out_err) err_sticky <= 1'b1;
  end
`else
  assign out_err    = 1'b0;
  assign err_sticky = 1'b0;
`endif

  assign bus.req0_ready = sel0 && a_free;
  assign bus.req1_ready = sel1 && a_free;
  assign bus.lut_addr   = lut_addr;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_id     = out_id;
  assign bus.out_err    = out_err;
  assign bus.err_sticky = err_sticky;

endmodule

// File: tb/tb_lut_u_arbiter.sv
// Bench for lut_u_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model (queue of in-flight requests).
module tb_lut_u_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lut_u_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  lut_u_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in LUT-U: 4*(nsyms_m1 - symbol + 1) when in range, 0 otherwise.
  function automatic logic [15:0] lut_val(input logic [7:0] a);
    int n, s;
    n = int'(a[7:4]);
    s = int'(a[3:0]);
    if (s > n) return 16'd0;
    return 16'(4 * (n - s + 1));
  endfunction

  function automatic logic exp_err(input logic [7:0] a);
`ifdef LUT_U_ARB_CHECK_EN
    return a[3:0] > a[7:4];
`else
    return 1'b0;
`endif
  endfunction

  assign bus.lut_q = lut_val(bus.lut_addr);

  typedef struct {
    logic       id;
    logic [7:0] addr;
    int         age;
  } item_t;

  item_t      q[$];
  logic       m_last;
  logic [7:0] m_lut_addr;
  logic       m_sticky;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_last     = 1'b1;
    m_lut_addr = 8'h00;
    m_sticky   = 1'b0;
  endtask

  // One clock: drive at posedge+1, check at negedge, update model at posedge.
  task automatic cycle(input logic v0, input logic [7:0] a0,
                       input logic v1, input logic [7:0] a1,
                       input logic ordy);
    logic vis, pop, s0, s1, room;
    item_t it;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.out_ready  = ordy;
    @(negedge clk);
    vis  = (q.size() > 0) && (q[0].age >= 1);
    pop  = vis && ordy;
    s0   = v0 && (!v1 || m_last);
    s1   = v1 && (!v0 || !m_last);
    room = (q.size() - int'(pop)) <= 1;
    chk("out_valid", 32'(bus.out_valid), 32'(vis));
    if (vis) begin
      chk("out_data", 32'(bus.out_data), 32'(lut_val(q[0].addr)));
      chk("out_id",   32'(bus.out_id),   32'(q[0].id));
      chk("out_err",  32'(bus.out_err),  32'(exp_err(q[0].addr)));
    end
    chk("req0_ready", 32'(bus.req0_ready), 32'(s0 && room));
    chk("req1_ready", 32'(bus.req1_ready), 32'(s1 && room));
    chk("lut_addr",   32'(bus.lut_addr),   32'(m_lut_addr));
    chk("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
    @(posedge clk);
    if (pop) begin
      if (exp_err(q[0].addr)) m_sticky = 1'b1;
      void'(q.pop_front());
    end
    foreach (q[i]) q[i].age++;
    if (room && (s0 || s1)) begin
      it.id   = s1;
      it.addr = s1 ? a1 : a0;
      it.age  = 0;
      q.push_back(it);
      m_last     = s1;
      m_lut_addr = it.addr;
    end
    #1;
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_addr  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = 8'h00;
    bus.out_ready  = 1'b1;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("rst_out_data",   32'(bus.out_data),   32'd0);
    chk("rst_out_id",     32'(bus.out_id),     32'd0);
    chk("rst_out_err",    32'(bus.out_err),    32'd0);
    chk("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
    chk("rst_lut_addr",   32'(bus.lut_addr),   32'd0);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    reset = 1'b0;

    // Contention: alternating 0,1,0,1 with data 4,64
    repeat (4) cycle(1'b1, 8'h00, 1'b1, 8'hF0, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Single request 0x32 -> 8 two cycles later
    cycle(1'b1, 8'h32, 1'b0, 8'h00, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Backpressure on a req1 stream of 0xA3
    cycle(1'b1 ^ 1'b1, 8'h00, 1'b1, 8'hA3, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 8'hA3, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Range error 0x25
    cycle(1'b1, 8'h25, 1'b0, 8'h00, 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Idle hold after 0xFF
    cycle(1'b1, 8'hFF, 1'b0, 8'h00, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Fill A and B under stall, then reset asynchronously mid-cycle
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 8'h54, 1'b0);
    chk("full_before_reset", 32'(q.size()), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_out_valid",  32'(bus.out_valid),  32'd0);
    chk("arst_lut_addr",   32'(bus.lut_addr),   32'd0);
    chk("arst_err_sticky", 32'(bus.err_sticky), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) cycle(1'b1, 8'h43, 1'b1, 8'h87, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 3) != 0));
    end
    repeat (4) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
